subservient_uart_loader: RTL and testbench
==========================================

SUBSERVIENT_UART_LOADER -- requirements
Module: subservient_uart_loader

Interface
REQ-001 The module SHALL have parameter CLKS_PER_BIT, default 87, which sets the UART bit period in wb_clk_i cycles.
REQ-002 The module SHALL have parameter MEMSIZE, default 512, which is the SRAM size in bytes and the maximum accepted image length.
REQ-003 The module SHALL have parameter RUN_DELAY, default 10, which is the number of cycles between the final write ack and run release.
REQ-004 Port: wb_clk_i  input  1  sole clock.
REQ-005 Port: wb_rst_i  input  1  reset, synchronous and active-high.
REQ-006 Port: uart_rx_i  input  1  asynchronous serial input, 8N1, idle high.
REQ-007 Port: wbm_adr_o  output  32  Wishbone write address, byte address, word-aligned.
REQ-008 Port: wbm_dat_o  output  32  write data, little-endian byte packing.
REQ-009 Port: wbm_sel_o  output  4  byte selects.
REQ-010 Port: wbm_we_o  output  1  write enable.
REQ-011 Port: wbm_stb_o  output  1  strobe.
REQ-012 Port: wbm_ack_i  input  1  slave acknowledge.
REQ-013 Port: run_o  output  1  drives the core's la_data_in; 0 means debug/load mode and 1 means the CPU runs.
REQ-014 Port: err_o  output  1  sticky error flag, set on framing, overrun or length error.

Function
REQ-015 uart_rx_i SHALL pass through a 2-flop synchronizer before sampling.
REQ-016 The receiver SHALL detect a start bit on a falling edge, confirm it low at mid-bit (CLKS_PER_BIT/2), and sample 8 data bits LSB-first at CLKS_PER_BIT intervals.
REQ-017 A stop bit sampled low SHALL discard the byte and set err_o.
REQ-018 Frame format SHALL be: sync byte 0xA5, then LEN_LO, then LEN_HI (16-bit byte count N), then N payload bytes.
REQ-019 The FSM SHALL use states SYNC, LEN_LO, LEN_HI, DATA, WRITE, PAD, WAIT_RUN and RUN.
REQ-020 In SYNC, a byte equal to 0xA5 SHALL advance to LEN_LO; any other byte SHALL be dropped with no error.
REQ-021 In LEN_HI, N==0 SHALL go to WAIT_RUN with no writes.
REQ-022 In LEN_HI, N>MEMSIZE SHALL set err_o and return to SYNC with run_o still 0.
REQ-023 In DATA, payload byte idx SHALL be stored in lane idx[1:0] of the word buffer; the lane-3 byte SHALL trigger WRITE at address (idx>>2)*4.
REQ-024 After byte N-1, if N%4!=0, PAD SHALL zero the unfilled upper lanes and issue one final WRITE.
REQ-025 WRITE SHALL assert stb=1, we=1, sel=4'b1111 with adr and dat stable, and SHALL hold them until wbm_ack_i is sampled high.
REQ-026 stb SHALL deassert the cycle after ack, giving at most one transaction in flight.
REQ-027 With no ack, WRITE SHALL wait indefinitely; there is no timeout.
REQ-028 Bytes arriving during WRITE SHALL be held in a 1-entry holding register and consumed after ack.
REQ-029 A second byte arriving while the holding register is full SHALL be dropped and set err_o; the idx count SHALL continue.
REQ-030 WAIT_RUN SHALL count RUN_DELAY cycles and then enter RUN; run_o SHALL go to 1 on the next edge.
REQ-031 RUN SHALL be terminal until reset: run_o stays 1, and all received bytes are ignored.
REQ-032 err_o SHALL be cleared only by reset.

Reset
REQ-033 When wb_rst_i=1, the FSM SHALL enter SYNC; idx, the counters and the holding register SHALL clear.
REQ-034 When wb_rst_i=1, stb, we, run_o and err_o SHALL be 0, adr and dat SHALL be 0, and sel SHALL be 0.
REQ-035 Reset asserted mid-transfer or mid-strobe SHALL abort immediately, drop stb in the same cycle, and require a full new frame afterwards.

Structure
REQ-036 A package subservient_loader_pkg SHALL hold the FSM state enum, SYNC_BYTE=8'hA5, and the LEN width (16).
REQ-037 The UART receiver SHALL be a sub-module subservient_uart_rx, with a byte-valid strobe and a framing-error pulse as outputs.

Verification
REQ-038 Frame A5 08 00 11 22 33 44 55 66 77 88 SHALL produce writes (0x0,0x44332211) then (0x4,0x88776655), then run_o=1 exactly RUN_DELAY+1 cycles after the second ack.
REQ-039 N=5 with payload 01..05 SHALL produce a second write (0x4,0x00000005).
REQ-040 Bytes 00 FF A5 00 00 SHALL produce no writes, run_o=1, and err_o=0.
REQ-041 Length 0x0201 (513) SHALL set err_o, produce no writes, and leave run_o=0; a subsequent valid frame SHALL still load.
REQ-042 With ack delayed 20 cycles and a stop bit forced low on byte 3, stb SHALL be held for the full 20 cycles, and err_o=1.
REQ-043 Reset asserted while stb=1 SHALL make stb=0 on the next edge, and a following clean frame SHALL load correctly.

Source files
------------

// File: rtl/subservient_uart_loader_pkg.sv
// Shared types and constants for the UART boot loader.
//   LEN_W      : width of the image length field and byte index
//   ADR_W/DAT_W: Wishbone address/data widths
//   SYNC_BYTE  : frame start marker
//   loader_state_e / rx_state_e : FSM encodings for the loader and receiver
package subservient_loader_pkg;

   localparam int         LEN_W     = 16;
   localparam int         ADR_W     = 32;
   localparam int         DAT_W     = 32;
   localparam logic [7:0] SYNC_BYTE = 8'hA5;

   typedef enum logic [2:0] {
      SYNC, LEN_LO, LEN_HI, DATA, WRITE, PAD, WAIT_RUN, RUN
   } loader_state_e;

   typedef enum logic [1:0] {
      RX_IDLE, RX_START, RX_DATA, RX_STOP
   } rx_state_e;

endpackage

// File: rtl/subservient_uart_loader_if.sv
// Wishbone write-only master bundle between the loader and the SRAM.
//   wbm_adr_o/wbm_dat_o/wbm_sel_o/wbm_we_o/wbm_stb_o : driven by the loader
//   wbm_ack_i                                        : driven by the slave
interface subservient_uart_loader_if;
   import subservient_loader_pkg::*;

   logic [ADR_W-1:0] wbm_adr_o;
   logic [DAT_W-1:0] wbm_dat_o;
   logic [3:0]       wbm_sel_o;
   logic             wbm_we_o;
   logic             wbm_stb_o;
   logic             wbm_ack_i;

   modport master (
      output wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o, wbm_stb_o,
      input  wbm_ack_i
   );

   modport slave (
      input  wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o, wbm_stb_o,
      output wbm_ack_i
   );
endinterface

// File: rtl/subservient_uart_rx.sv
// 8N1 UART receiver with a 2-flop input synchronizer.
//   clk_i, rst_i : clock, synchronous active-high reset
//   rx_i         : asynchronous serial line, idle high
//   data_o       : last received byte, valid while valid_o pulses
//   valid_o      : one-cycle pulse for a byte with a good stop bit
//   frame_err_o  : one-cycle pulse when the stop bit samples low
module subservient_uart_rx
   import subservient_loader_pkg::*;
#(
   parameter int CLKS_PER_BIT = 87
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       rx_i,
   output logic [7:0] data_o,
   output logic       valid_o,
   output logic       frame_err_o
);
   localparam int            CW        = $clog2(CLKS_PER_BIT + 1);
   localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);

   rx_state_e     st_q;
   logic          sync1_q, sync2_q, prev_q;
   logic [CW-1:0] cnt_q;
   logic [2:0]    bit_q;
   logic [7:0]    shift_q, data_q;
   logic          valid_q, ferr_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         st_q    <= RX_IDLE;
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         prev_q  <= 1'b1;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         sync1_q <= rx_i;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
         case (st_q)
            RX_IDLE: begin
               if (prev_q && !sync2_q) begin
                  st_q  <= RX_START;
                  cnt_q <= HALF_LOAD;
               end
            end
            RX_START: begin
               if (cnt_q == '0) begin
                  // a start bit that is high again at mid-bit was a glitch
                  if (!sync2_q) begin
                     st_q  <= RX_DATA;
                     cnt_q <= FULL_LOAD;
                     bit_q <= '0;
                  end else begin
                     st_q <= RX_IDLE;
                  end
               end else begin
                  cnt_q <= cnt_q - CW'(1);
               end
            end
            RX_DATA: begin
               if (cnt_q == '0) begin
                  shift_q <= {sync2_q, shift_q[7:1]};
                  cnt_q   <= FULL_LOAD;
                  bit_q   <= bit_q + 3'd1;
                  if (bit_q == 3'd7) st_q <= RX_STOP;
               end else begin
                  cnt_q <= cnt_q - CW'(1);
               end
            end
            RX_STOP: begin
               if (cnt_q == '0) begin
                  st_q <= RX_IDLE;
                  if (sync2_q) begin
                     valid_q <= 1'b1;
                     data_q  <= shift_q;
                  end else begin
                     ferr_q <= 1'b1;
                  end
               end else begin
                  cnt_q <= cnt_q - CW'(1);
               end
            end
            default: st_q <= RX_IDLE;
         endcase
      end
   end

   assign data_o      = data_q;
   assign valid_o     = valid_q;
   assign frame_err_o = ferr_q;
endmodule

// File: rtl/subservient_uart_loader.sv
// UART boot loader: receives A5, LEN_LO, LEN_HI, payload and writes the
// payload into SRAM as 32-bit little-endian words, then releases the CPU.
//   wb_clk_i, wb_rst_i : clock, synchronous active-high reset
//   uart_rx_i          : serial image input
//   wbm                : Wishbone write master
//   run_o              : 0 = load mode, 1 = CPU runs (terminal until reset)
//   err_o              : sticky framing / overrun / length error
//
// state    | meaning
// SYNC     | hunting for the sync byte
// LEN_LO   | expecting low length byte
// LEN_HI   | expecting high length byte, length checked here
// DATA     | packing payload bytes into the word buffer
// WRITE    | strobe held until the slave acks
// PAD      | issue the final partial word, upper lanes zero
// WAIT_RUN | counting down before release
// RUN      | CPU released, input ignored
module subservient_uart_loader
   import subservient_loader_pkg::*;
#(
   parameter int CLKS_PER_BIT = 87,
   parameter int MEMSIZE      = 512,
   parameter int RUN_DELAY    = 10
) (
   input  logic                      wb_clk_i,
   input  logic                      wb_rst_i,
   input  logic                      uart_rx_i,
   subservient_uart_loader_if.master wbm,
   output logic                      run_o,
   output logic                      err_o
);
   localparam logic [LEN_W-1:0] MEM_MAX  = LEN_W'(MEMSIZE);
   localparam logic [LEN_W-1:0] DLY_LOAD = (RUN_DELAY > 0) ? LEN_W'(RUN_DELAY - 1) : '0;

   logic [7:0]       rx_data;
   logic             rx_valid, rx_ferr;

   loader_state_e    state_q;
   logic [LEN_W-1:0] len_q, idx_q, dly_q;
   logic [DAT_W-1:0] buf_q, dat_q;
   logic [ADR_W-1:0] adr_q;
   logic [7:0]       hold_q;
   logic             hold_vld_q;
   logic [3:0]       sel_q;
   logic             we_q, stb_q, run_q, err_q;

   logic [LEN_W-1:0] idx_d, len_d;
   logic [DAT_W-1:0] word_d;
   logic             consume;

   subservient_uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
      .clk_i       (wb_clk_i),
      .rst_i       (wb_rst_i),
      .rx_i        (uart_rx_i),
      .data_o      (rx_data),
      .valid_o     (rx_valid),
      .frame_err_o (rx_ferr)
   );

   // Every received byte lands in the holding register first; the FSM
   // drains it only in the byte-consuming states, so bytes that arrive
   // during a Wishbone write simply wait there.
   assign consume = hold_vld_q && (state_q inside {SYNC, LEN_LO, LEN_HI, DATA});
   assign idx_d   = idx_q + LEN_W'(1);
   assign len_d   = {hold_q, len_q[7:0]};

   always_comb begin
      word_d = buf_q;
      word_d[{idx_q[1:0], 3'b000} +: 8] = hold_q;
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q    <= SYNC;
         len_q      <= '0;
         idx_q      <= '0;
         dly_q      <= '0;
         buf_q      <= '0;
         hold_q     <= '0;
         hold_vld_q <= 1'b0;
         adr_q      <= '0;
         dat_q      <= '0;
         sel_q      <= '0;
         we_q       <= 1'b0;
         stb_q      <= 1'b0;
         run_q      <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         if (rx_ferr) err_q <= 1'b1;
         if (rx_valid && !(state_q inside {WAIT_RUN, RUN})) begin
            if (hold_vld_q && !consume) begin
               err_q <= 1'b1;
            end else begin
               hold_q     <= rx_data;
               hold_vld_q <= 1'b1;
            end
         end else if (consume) begin
            hold_vld_q <= 1'b0;
         end

         case (state_q)
            SYNC: begin
               if (consume && hold_q == SYNC_BYTE) state_q <= LEN_LO;
            end
            LEN_LO: begin
               if (consume) begin
                  len_q[7:0] <= hold_q;
                  state_q    <= LEN_HI;
               end
            end
            LEN_HI: begin
               if (consume) begin
                  if (len_d == '0) begin
                     dly_q   <= DLY_LOAD;
                     state_q <= WAIT_RUN;
                  end else if (len_d > MEM_MAX) begin
                     err_q   <= 1'b1;
                     state_q <= SYNC;
                  end else begin
                     len_q   <= len_d;
                     idx_q   <= '0;
                     buf_q   <= '0;
                     state_q <= DATA;
                  end
               end
            end
            DATA: begin
               if (consume) begin
                  idx_q <= idx_d;
                  if (idx_q[1:0] == 2'd3) begin
                     adr_q   <= {{(ADR_W-LEN_W){1'b0}}, idx_q[LEN_W-1:2], 2'b00};
                     dat_q   <= word_d;
                     sel_q   <= 4'b1111;
                     we_q    <= 1'b1;
                     stb_q   <= 1'b1;
                     buf_q   <= '0;
                     state_q <= WRITE;
                  end else begin
                     buf_q <= word_d;
                     if (idx_d == len_q) state_q <= PAD;
                  end
               end
            end
            PAD: begin
               // idx is N here and N is not a multiple of 4, so idx shares
               // the word of the last byte; unfilled lanes are still zero.
               adr_q   <= {{(ADR_W-LEN_W){1'b0}}, idx_q[LEN_W-1:2], 2'b00};
               dat_q   <= buf_q;
               sel_q   <= 4'b1111;
               we_q    <= 1'b1;
               stb_q   <= 1'b1;
               buf_q   <= '0;
               state_q <= WRITE;
            end
            WRITE: begin
               if (wbm.wbm_ack_i) begin
                  stb_q <= 1'b0;
                  we_q  <= 1'b0;
                  sel_q <= '0;
                  if (idx_q == len_q) begin
                     dly_q   <= DLY_LOAD;
                     state_q <= WAIT_RUN;
                  end else begin
                     state_q <= DATA;
                  end
               end
            end
            WAIT_RUN: begin
               if (dly_q == '0) state_q <= RUN;
               else             dly_q   <= dly_q - LEN_W'(1);
            end
            RUN: run_q <= 1'b1;
            default: state_q <= SYNC;
         endcase
      end
   end

   assign wbm.wbm_adr_o = adr_q;
   assign wbm.wbm_dat_o = dat_q;
   assign wbm.wbm_sel_o = sel_q;
   assign wbm.wbm_we_o  = we_q;
   assign wbm.wbm_stb_o = stb_q;
   assign run_o         = run_q;
   assign err_o         = err_q;
endmodule

// File: tb/tb_subservient_uart_loader.sv
// Self-checking bench for subservient_uart_loader: drives UART frames,
// acts as a delayed-ack Wishbone slave and compares every write and the
// run release timing against a frame-level model.
module tb_subservient_uart_loader;
   localparam int CPB       = 16;
   localparam int MEMSIZE   = 512;
   localparam int RUN_DELAY = 10;

   logic clk     = 1'b0;
   logic rst     = 1'b1;
   logic uart_rx = 1'b1;
   logic run_o, err_o;

   subservient_uart_loader_if wb();

   subservient_uart_loader #(
      .CLKS_PER_BIT (CPB),
      .MEMSIZE      (MEMSIZE),
      .RUN_DELAY    (RUN_DELAY)
   ) dut (
      .wb_clk_i  (clk),
      .wb_rst_i  (rst),
      .uart_rx_i (uart_rx),
      .wbm       (wb),
      .run_o     (run_o),
      .err_o     (err_o)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc = 0, ack_cyc = -1, run_rise_cyc = -1;
   int stb_cnt = 0, stb_len_last = 0, ack_dly = 0;
   logic        run_prev = 1'b0;
   logic [31:0] prev_adr = '0, prev_dat = '0;
   logic [31:0] exp_adr[$], exp_dat[$], log_adr[$], log_dat[$];
   bit          m_run, m_err;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Frame-level model: hunt for A5, read the length, reject oversize
   // images, otherwise pack the payload into little-endian words.
   function automatic void model(input logic [7:0] b[$]);
      int p, n;
      logic [31:0] w;
      exp_adr.delete();
      exp_dat.delete();
      m_run = 0;
      m_err = 0;
      p = 0;
      while (p < b.size() && !m_run) begin
         if (b[p] != 8'hA5 || p + 2 >= b.size()) begin
            p++;
            continue;
         end
         n = int'(b[p+2]) * 256 + int'(b[p+1]);
         p += 3;
         if (n > MEMSIZE) begin
            m_err = 1;
            continue;
         end
         for (int a = 0; a < n; a += 4) begin
            w = '0;
            for (int k = 0; k < 4; k++)
               if (a + k < n) w |= 32'(b[p+a+k]) << (8 * k);
            exp_adr.push_back(32'(a));
            exp_dat.push_back(w);
         end
         m_run = 1;
      end
   endfunction

   // Wishbone slave, scoreboard and run-timing compare, all on negedges.
   initial begin
      wb.wbm_ack_i = 1'b0;
      forever begin
         @(negedge clk);
         cyc++;
         if (rst) begin
            wb.wbm_ack_i = 1'b0;
            stb_cnt = 0;
         end else if (wb.wbm_ack_i) begin
            wb.wbm_ack_i = 1'b0;
            check("stb_drop_after_ack", 32'(wb.wbm_stb_o), 32'd0);
            stb_cnt = 0;
            if (m_run && exp_adr.size() == 0) ack_cyc = cyc;
         end else if (wb.wbm_stb_o) begin
            check("stb_we", 32'(wb.wbm_we_o), 32'd1);
            check("stb_sel", 32'(wb.wbm_sel_o), 32'hF);
            if (stb_cnt > 0) begin
               check("adr_stable", wb.wbm_adr_o, prev_adr);
               check("dat_stable", wb.wbm_dat_o, prev_dat);
            end
            prev_adr = wb.wbm_adr_o;
            prev_dat = wb.wbm_dat_o;
            stb_cnt++;
            if (stb_cnt > ack_dly) begin
               wb.wbm_ack_i = 1'b1;
               stb_len_last = stb_cnt;
               log_adr.push_back(wb.wbm_adr_o);
               log_dat.push_back(wb.wbm_dat_o);
               n_checks++;
               if (exp_adr.size() == 0) begin
                  n_fail++;
                  $display("FAIL unexpected_write: got adr 0x%08h dat 0x%08h, none required",
                           wb.wbm_adr_o, wb.wbm_dat_o);
               end else begin
                  n_checks--;
                  check("wr_adr", wb.wbm_adr_o, exp_adr.pop_front());
                  check("wr_dat", wb.wbm_dat_o, exp_dat.pop_front());
               end
            end
         end else begin
            stb_cnt = 0;
         end
         if (ack_cyc >= 0 && cyc > ack_cyc && cyc <= ack_cyc + RUN_DELAY + 3)
            check("run_timing", 32'(run_o), 32'(cyc >= ack_cyc + RUN_DELAY + 1));
         if (run_o && !run_prev) run_rise_cyc = cyc;
         run_prev = run_o;
      end
   end

   task automatic send_byte(input logic [7:0] b, input bit bad_stop);
      uart_rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         uart_rx = b[i];
         repeat (CPB) @(negedge clk);
      end
      uart_rx = !bad_stop;
      repeat (CPB) @(negedge clk);
      uart_rx = 1'b1;
      repeat (bad_stop ? 2 * CPB : CPB) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] f[$], input int bad, input int from, input int to);
      for (int i = from; i < to; i++) send_byte(f[i], i == bad);
   endtask

   task automatic start_test(input logic [7:0] f[$], input int bad, input int dly);
      logic [7:0] g[$];
      foreach (f[i]) if (i != bad) g.push_back(f[i]);
      model(g);
      if (bad >= 0) m_err = 1;
      ack_dly      = dly;
      ack_cyc      = -1;
      run_rise_cyc = -1;
      log_adr.delete();
      log_dat.delete();
   endtask

   task automatic finish_test(input string tag);
      if (m_run) begin
         for (int i = 0; i < 1000 && run_o !== 1'b1; i++) @(negedge clk);
      end else begin
         repeat (2 * CPB) @(negedge clk);
      end
      repeat (RUN_DELAY + 4) @(negedge clk);
      check({tag, "_run"}, 32'(run_o), 32'(m_run));
      check({tag, "_err"}, 32'(err_o), 32'(m_err));
      check({tag, "_writes_left"}, 32'(exp_adr.size()), 32'd0);
      if (ack_cyc >= 0)
         check({tag, "_run_delay"}, 32'(run_rise_cyc - ack_cyc), 32'd11);
   endtask

   task automatic do_reset(input string tag);
      @(negedge clk);
      rst     = 1'b1;
      uart_rx = 1'b1;
      repeat (2) @(negedge clk);
      check({tag, "_rst_ctl"},
            {25'd0, wb.wbm_stb_o, wb.wbm_we_o, wb.wbm_sel_o, run_o}, 32'd0);
      check({tag, "_rst_err"}, 32'(err_o), 32'd0);
      check({tag, "_rst_adr_dat"}, wb.wbm_adr_o | wb.wbm_dat_o, 32'd0);
      rst = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] f[$];

      // two full words, then timed release
      do_reset("t1");
      f = '{8'hA5, 8'h08, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
      start_test(f, -1, 0);
      send_frame(f, -1, 0, f.size());
      finish_test("t1");
      check("t1_nwrites", 32'(log_adr.size()), 32'd2);
      if (log_adr.size() == 2) begin
         check("t1_w0_adr", log_adr[0], 32'h0);
         check("t1_w0_dat", log_dat[0], 32'h44332211);
         check("t1_w1_adr", log_adr[1], 32'h4);
         check("t1_w1_dat", log_dat[1], 32'h88776655);
      end

      // partial final word is zero padded
      do_reset("t2");
      f = '{8'hA5, 8'h05, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
      start_test(f, -1, 1);
      send_frame(f, -1, 0, f.size());
      finish_test("t2");
      check("t2_nwrites", 32'(log_adr.size()), 32'd2);
      if (log_adr.size() == 2) begin
         check("t2_w1_adr", log_adr[1], 32'h4);
         check("t2_w1_dat", log_dat[1], 32'h00000005);
      end

      // junk before sync, zero length: no writes, release, no error
      do_reset("t3");
      f = '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h00};
      start_test(f, -1, 0);
      send_frame(f, -1, 0, f.size());
      finish_test("t3");
      check("t3_nwrites", 32'(log_adr.size()), 32'd0);

      // oversize length rejected, then a valid frame still loads
      do_reset("t4");
      f = '{8'hA5, 8'h01, 8'h02, 8'hA5, 8'h04, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
      start_test(f, -1, 2);
      send_frame(f, -1, 0, 3);
      repeat (CPB) @(negedge clk);
      check("t4_len_err", 32'(err_o), 32'd1);
      check("t4_len_run", 32'(run_o), 32'd0);
      check("t4_len_nwrites", 32'(log_adr.size()), 32'd0);
      send_frame(f, -1, 3, f.size());
      finish_test("t4");
      if (log_dat.size() == 1) check("t4_w0_dat", log_dat[0], 32'hDDCCBBAA);
      else check("t4_nwrites", 32'(log_dat.size()), 32'd1);

      // bad stop bit on byte 3, slow ack held for 20 cycles
      do_reset("t5");
      f = '{8'hA5, 8'h04, 8'h00, 8'hEE, 8'h11, 8'h22, 8'h33, 8'h44};
      start_test(f, 3, 20);
      send_frame(f, 3, 0, f.size());
      finish_test("t5");
      check("t5_stb_held", 32'(stb_len_last), 32'd21);

      // reset while strobing, then a clean frame
      do_reset("t6");
      f = '{8'hA5, 8'h04, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
      start_test(f, -1, 100000);
      send_frame(f, -1, 0, f.size());
      for (int i = 0; i < 400 && wb.wbm_stb_o !== 1'b1; i++) @(negedge clk);
      check("t6_stb_up", 32'(wb.wbm_stb_o), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      check("t6_stb_drop_on_reset", 32'(wb.wbm_stb_o), 32'd0);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      f = '{8'hA5, 8'h04, 8'h00, 8'h0D, 8'h0C, 8'h0B, 8'h0A};
      start_test(f, -1, 3);
      send_frame(f, -1, 0, f.size());
      finish_test("t6");
      if (log_dat.size() == 1) check("t6_w0_dat", log_dat[0], 32'h0A0B0C0D);
      else check("t6_nwrites", 32'(log_dat.size()), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
